// File: rtl/exc_ctrl.sv
// Exception / interrupt / ERET controller at commit: classifies the committing
// instruction, emits one-cycle CP0 write strobes and holds a fetch redirect until it is accepted.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [31:0] commit_pc,
  input  logic        commit_bd,
  input  logic [6:0]  commit_exc,
  input  logic [31:0] commit_badvaddr,
  input  logic        commit_eret,
  input  logic        cp0_has_int,
  input  logic [31:0] cp0_epc,
  output logic        w_cp0_update_ena,
  output logic [4:0]  w_cp0_exccode,
  output logic        w_cp0_bd,
  output logic        w_cp0_exl,
  output logic [31:0] w_cp0_epc,
  output logic        w_cp0_badvaddr_ena,
  output logic [31:0] w_cp0_badvaddr,
  output logic        cp0_cls_exl,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic [15:0] exc_count
);

  // Handshakes: a commit transfers on a cycle where commit_valid & commit_ready;
  // a redirect transfers on a cycle where redirect_valid & redirect_ready, and
  // redirect_valid/redirect_pc stay stable until then.

  typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_t;

  state_t      state;
  state_t      state_next;

  logic        take;
  logic        has_exc;
  logic        is_event;
  logic [4:0]  exccode_c;
  logic        badvaddr_ena_c;
  logic [31:0] badvaddr_c;
  logic [31:0] epc_c;

  logic        commit_ready_n;
  logic        update_n;
  logic        cls_n;
  logic        flush_n;
  logic        redirect_valid_n;
  logic [31:0] redirect_pc_n;
  logic [15:0] exc_count_n;

  assign take     = commit_valid & commit_ready & (state == IDLE);
  assign has_exc  = cp0_has_int | (|commit_exc);
  assign is_event = has_exc | commit_eret;
  assign epc_c    = commit_bd ? (commit_pc - 32'd4) : commit_pc;

  // Cause priority: interrupt beats every synchronous exception; ERET is lowest.
  always_comb begin
    exccode_c      = 5'd0;
    badvaddr_ena_c = 1'b0;
    badvaddr_c     = commit_badvaddr;
    if (cp0_has_int) begin
      exccode_c = 5'd0;
    end else if (commit_exc[6]) begin
      exccode_c      = 5'd4;
      badvaddr_ena_c = 1'b1;
      badvaddr_c     = commit_pc;
    end else if (commit_exc[5]) begin
      exccode_c = 5'd10;
    end else if (commit_exc[4]) begin
      exccode_c = 5'd12;
    end else if (commit_exc[3]) begin
      exccode_c = 5'd8;
    end else if (commit_exc[2]) begin
      exccode_c = 5'd9;
    end else if (commit_exc[1]) begin
      exccode_c      = 5'd4;
      badvaddr_ena_c = 1'b1;
    end else if (commit_exc[0]) begin
      exccode_c      = 5'd5;
      badvaddr_ena_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take && is_event) state_next = REDIR;
      REDIR:   if (redirect_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    commit_ready_n   = (state_next == IDLE);
    update_n         = take & has_exc;
    cls_n            = take & commit_eret & ~has_exc;
    flush_n          = take & is_event;
    redirect_valid_n = (state_next == REDIR);
    redirect_pc_n    = redirect_pc;
    if (take && is_event) begin
      redirect_pc_n = has_exc ? EXC_VECTOR : cp0_epc;
    end
    exc_count_n = exc_count;
    if (update_n && (exc_count != 16'hFFFF)) begin
      exc_count_n = exc_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_ready       <= 1'b0;
      w_cp0_update_ena   <= 1'b0;
      w_cp0_exccode      <= 5'd0;
      w_cp0_bd           <= 1'b0;
      w_cp0_exl          <= 1'b0;
      w_cp0_epc          <= 32'd0;
      w_cp0_badvaddr_ena <= 1'b0;
      w_cp0_badvaddr     <= 32'd0;
      cp0_cls_exl        <= 1'b0;
      flush              <= 1'b0;
      redirect_valid     <= 1'b0;
      redirect_pc        <= 32'd0;
      exc_count          <= 16'd0;
    end else begin
      commit_ready       <= commit_ready_n;
      w_cp0_update_ena   <= update_n;
      w_cp0_exl          <= update_n;
      w_cp0_badvaddr_ena <= update_n & badvaddr_ena_c;
      cp0_cls_exl        <= cls_n;
      flush              <= flush_n;
      redirect_valid     <= redirect_valid_n;
      redirect_pc        <= redirect_pc_n;
      exc_count          <= exc_count_n;
      // Data fields only move with the strobe so CP0 sees a coherent record.
      if (update_n) begin
        w_cp0_exccode  <= exccode_c;
        w_cp0_bd       <= commit_bd;
        w_cp0_epc      <= epc_c;
        w_cp0_badvaddr <= badvaddr_c;
      end
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios plus random commits; CP0/redirect
// records are checked by a scoreboard fed with expectations at drive time.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  typedef struct packed {
    logic        upd;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] epc;
    logic        bva_ena;
    logic [31:0] bva;
    logic        cls;
    logic [31:0] rpc;
  } exp_t;

  localparam int EW = $bits(exp_t);

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic [6:0]  commit_exc;
  logic [31:0] commit_badvaddr;
  logic        commit_eret;
  logic        cp0_has_int;
  logic [31:0] cp0_epc;
  logic        w_cp0_update_ena;
  logic [4:0]  w_cp0_exccode;
  logic        w_cp0_bd;
  logic        w_cp0_exl;
  logic [31:0] w_cp0_epc;
  logic        w_cp0_badvaddr_ena;
  logic [31:0] w_cp0_badvaddr;
  logic        cp0_cls_exl;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic [15:0] exc_count;

  logic [EW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [15:0]   exp_count;

  exc_ctrl #(.EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_bd(commit_bd), .commit_exc(commit_exc),
    .commit_badvaddr(commit_badvaddr), .commit_eret(commit_eret),
    .cp0_has_int(cp0_has_int), .cp0_epc(cp0_epc),
    .w_cp0_update_ena(w_cp0_update_ena), .w_cp0_exccode(w_cp0_exccode),
    .w_cp0_bd(w_cp0_bd), .w_cp0_exl(w_cp0_exl), .w_cp0_epc(w_cp0_epc),
    .w_cp0_badvaddr_ena(w_cp0_badvaddr_ena), .w_cp0_badvaddr(w_cp0_badvaddr),
    .cp0_cls_exl(cp0_cls_exl), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .exc_count(exc_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_bd = 1'b0;
    commit_exc = '0; commit_badvaddr = '0; commit_eret = 1'b0;
    cp0_has_int = 1'b0; cp0_epc = '0; redirect_ready = 1'b1; exp_count = '0;
  end

  function automatic exp_t mk_exp(input logic upd, input logic [4:0] code, input logic bd,
                                  input logic [31:0] epc, input logic bva_ena,
                                  input logic [31:0] bva, input logic cls, input logic [31:0] rpc);
    exp_t e;
    e.upd = upd; e.code = code; e.bd = bd; e.epc = epc;
    e.bva_ena = bva_ena; e.bva = bva; e.cls = cls; e.rpc = rpc;
    return e;
  endfunction

  // Reference model of one accepted commit.
  function automatic exp_t model(input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                                 input logic [31:0] bva, input logic eret, input logic intr,
                                 input logic [31:0] cepc);
    exp_t e = '0;
    if (intr || exc != 7'd0) begin
      e.upd = 1'b1; e.bd = bd; e.rpc = VEC;
      e.epc = bd ? pc - 32'd4 : pc;
      if (intr)          e.code = 5'd0;
      else if (exc[6]) begin e.code = 5'd4; e.bva_ena = 1'b1; e.bva = pc; end
      else if (exc[5])   e.code = 5'd10;
      else if (exc[4])   e.code = 5'd12;
      else if (exc[3])   e.code = 5'd8;
      else if (exc[2])   e.code = 5'd9;
      else if (exc[1]) begin e.code = 5'd4; e.bva_ena = 1'b1; e.bva = bva; end
      else begin e.code = 5'd5; e.bva_ena = 1'b1; e.bva = bva; end
    end else if (eret) begin
      e.cls = 1'b1; e.rpc = cepc;
    end
    return e;
  endfunction

  // driver tasks
  task automatic wait_ready();
    for (int i = 0; i < 20 && commit_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (commit_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: commit_ready=%b required 1 within 20 cycles", commit_ready);
    end
  endtask

  // Presents one commit, lets it be accepted, and returns #1 after that edge (T+1).
  task automatic drive_commit(input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                              input logic [31:0] bva, input logic eret, input logic intr,
                              input logic [31:0] cepc);
    wait_ready();
    commit_valid = 1'b1; commit_pc = pc; commit_bd = bd; commit_exc = exc;
    commit_badvaddr = bva; commit_eret = eret; cp0_has_int = intr; cp0_epc = cepc;
    @(posedge clk); #1;
    commit_valid = 1'b0; commit_exc = '0; commit_eret = 1'b0; cp0_has_int = 1'b0;
    cp0_epc = 32'h1357_9BDF;
  endtask

  // scoreboard: every flush pulse must match the oldest expected record
  always @(negedge clk) begin
    if (flush === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_flush: code=%0d rpc=%h with no expected event", w_cp0_exccode, redirect_pc);
      end else begin
        exp_t e;
        logic bad;
        e = exp_t'(exp_q.pop_front());
        bad = (w_cp0_update_ena !== e.upd) || (cp0_cls_exl !== e.cls) ||
              (redirect_pc !== e.rpc) || (redirect_valid !== 1'b1);
        if (e.upd) begin
          bad = bad || (w_cp0_exccode !== e.code) || (w_cp0_bd !== e.bd) ||
                (w_cp0_epc !== e.epc) || (w_cp0_exl !== 1'b1) ||
                (w_cp0_badvaddr_ena !== e.bva_ena);
          if (e.bva_ena) bad = bad || (w_cp0_badvaddr !== e.bva);
        end else begin
          bad = bad || (w_cp0_badvaddr_ena !== 1'b0) || (w_cp0_exl !== 1'b0);
        end
        if (bad) begin
          errors++;
          $display("FAIL sb_event: got upd=%b code=%0d bd=%b epc=%h exl=%b bvae=%b bva=%h cls=%b rv=%b rpc=%h; required upd=%b code=%0d bd=%b epc=%h bvae=%b bva=%h cls=%b rpc=%h",
                   w_cp0_update_ena, w_cp0_exccode, w_cp0_bd, w_cp0_epc, w_cp0_exl,
                   w_cp0_badvaddr_ena, w_cp0_badvaddr, cp0_cls_exl, redirect_valid, redirect_pc,
                   e.upd, e.code, e.bd, e.epc, e.bva_ena, e.bva, e.cls, e.rpc);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({commit_ready, w_cp0_update_ena, w_cp0_exl, w_cp0_badvaddr_ena, cp0_cls_exl,
         flush, redirect_valid} !== 7'd0 || exc_count !== 16'd0 || redirect_pc !== 32'd0 ||
        w_cp0_epc !== 32'd0 || w_cp0_exccode !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rv=%b flush=%b cnt=%h rpc=%h required all 0",
               commit_ready, redirect_valid, flush, exc_count, redirect_pc);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (commit_ready !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b rv=%b required 1 0", commit_ready, redirect_valid);
    end
  endtask

  task automatic test_ov_hold();
    redirect_ready = 1'b0;
    exp_q.push_back(mk_exp(1'b1, 5'd12, 1'b0, 32'h8000_0100, 1'b0, 32'd0, 1'b0, VEC));
    drive_commit(32'h8000_0100, 1'b0, 7'b001_0000, 32'd0, 1'b0, 1'b0, 32'd0);
    exp_count = exp_count + 16'd1;
    checks++;
    if (commit_ready !== 1'b0 || redirect_valid !== 1'b1 || exc_count !== exp_count) begin
      errors++;
      $display("FAIL ov_t1: ready=%b rv=%b cnt=%h required 0 1 %h", commit_ready, redirect_valid, exc_count, exp_count);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (commit_ready !== 1'b0 || redirect_valid !== 1'b1 || flush !== 1'b0 ||
          w_cp0_update_ena !== 1'b0 || redirect_pc !== VEC) begin
        errors++;
        $display("FAIL ov_hold: ready=%b rv=%b flush=%b upd=%b rpc=%h required 0 1 0 0 %h",
                 commit_ready, redirect_valid, flush, w_cp0_update_ena, redirect_pc, VEC);
      end
    end
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (commit_ready !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL ov_release: ready=%b rv=%b required 1 0", commit_ready, redirect_valid);
    end
  endtask

  task automatic test_cause_table();
    logic [31:0] t_pc[11]   = '{32'h8000_0204, 32'h0000_0000, 32'h8000_0031, 32'h8000_0040,
                                32'h8000_0050, 32'h8000_0060, 32'h8000_0070, 32'h8000_0080,
                                32'h8000_0090, 32'h8000_0020, 32'h8000_0010};
    logic        t_bd[11]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [6:0]  t_exc[11]  = '{7'h02, 7'h41, 7'h40, 7'h01, 7'h06, 7'h0C, 7'h18, 7'h30,
                                7'h02, 7'h20, 7'h08};
    logic [31:0] t_bva[11]  = '{32'h3, 32'h5555, 32'h1234, 32'hDEAD_BEEF, 32'h77, 32'h0,
                                32'h0, 32'h0, 32'h99, 32'h0, 32'h0};
    logic        t_eret[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        t_int[11]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0]  t_code[11] = '{5'd4, 5'd4, 5'd4, 5'd5, 5'd9, 5'd8, 5'd12, 5'd10, 5'd0, 5'd10, 5'd0};
    logic [31:0] t_epc[11]  = '{32'h8000_0200, 32'hFFFF_FFFC, 32'h8000_0031, 32'h8000_0040,
                                32'h8000_0050, 32'h8000_005C, 32'h8000_0070, 32'h8000_0080,
                                32'h8000_0090, 32'h8000_001C, 32'h8000_0010};
    logic        t_bvae[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_xbva[11] = '{32'h3, 32'h0, 32'h8000_0031, 32'hDEAD_BEEF, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    redirect_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(mk_exp(1'b1, t_code[i], t_bd[i], t_epc[i], t_bvae[i], t_xbva[i], 1'b0, VEC));
      drive_commit(t_pc[i], t_bd[i], t_exc[i], t_bva[i], t_eret[i], t_int[i], 32'h8000_0ABC);
      exp_count = exp_count + 16'd1;
      checks++;
      if (cp0_cls_exl !== 1'b0 || redirect_valid !== 1'b1) begin
        errors++;
        $display("FAIL cause_%0d: cls=%b rv=%b required 0 1", i, cp0_cls_exl, redirect_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (exc_count !== exp_count || commit_ready !== 1'b1) begin
        errors++;
        $display("FAIL cause_%0d_count: cnt=%h ready=%b required %h 1", i, exc_count, commit_ready, exp_count);
      end
    end
  endtask

  task automatic test_eret();
    int vcount = 0;
    int cls_cnt = 0;
    logic pc_bad = 1'b0;
    redirect_ready = 1'b0;
    exp_q.push_back(mk_exp(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h8000_0400));
    drive_commit(32'h8000_0300, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 32'h8000_0400);
    for (int cyc = 0; cyc < 10 && redirect_valid === 1'b1; cyc++) begin
      vcount++;
      if (cp0_cls_exl === 1'b1) cls_cnt++;
      if (redirect_pc !== 32'h8000_0400 || w_cp0_update_ena !== 1'b0) pc_bad = 1'b1;
      if (cyc == 3) redirect_ready = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (vcount != 4 || cls_cnt != 1 || pc_bad) begin
      errors++;
      $display("FAIL eret_hold: valid_cycles=%0d cls_pulses=%0d pc_bad=%b required 4 1 0", vcount, cls_cnt, pc_bad);
    end
    checks++;
    if (exc_count !== exp_count || commit_ready !== 1'b1) begin
      errors++;
      $display("FAIL eret_count: cnt=%h ready=%b required %h 1", exc_count, commit_ready, exp_count);
    end
  endtask

  task automatic test_ignore_in_redir();
    logic bad = 1'b0;
    redirect_ready = 1'b0;
    exp_q.push_back(mk_exp(1'b1, 5'd8, 1'b0, 32'h8000_0500, 1'b0, 32'd0, 1'b0, VEC));
    drive_commit(32'h8000_0500, 1'b0, 7'h08, 32'd0, 1'b0, 1'b0, 32'd0);
    exp_count = exp_count + 16'd1;
    commit_valid = 1'b1; commit_exc = 7'h10; commit_eret = 1'b1; cp0_has_int = 1'b1;
    commit_pc = 32'h8000_0600;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (commit_ready !== 1'b0 || flush !== 1'b0 || redirect_pc !== VEC) bad = 1'b1;
    end
    commit_valid = 1'b0; commit_exc = '0; commit_eret = 1'b0; cp0_has_int = 1'b0;
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bad || exc_count !== exp_count || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_redir: bad=%b cnt=%h rv=%b required 0 %h 0", bad, exc_count, redirect_valid, exp_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int kind = $urandom_range(0, 3);
      logic [31:0] pc = $urandom;
      logic bd = 1'($urandom_range(0, 1));
      logic [6:0] exc = 7'd0;
      logic eret = 1'b0;
      logic intr = 1'b0;
      logic [31:0] bva = $urandom;
      logic [31:0] cepc = $urandom;
      logic ev;
      case (kind)
        1: exc = 7'($urandom_range(1, 127));
        2: eret = 1'b1;
        3: begin intr = 1'b1; exc = 7'($urandom_range(0, 127)); eret = 1'($urandom_range(0, 1)); end
        default: ;
      endcase
      ev = intr | (|exc) | eret;
      if (ev) exp_q.push_back(model(pc, bd, exc, bva, eret, intr, cepc));
      redirect_ready = 1'b0;
      drive_commit(pc, bd, exc, bva, eret, intr, cepc);
      if (intr || exc != 7'd0) exp_count = exp_count + 16'd1;
      if (!ev) begin
        checks++;
        if (flush !== 1'b0 || commit_ready !== 1'b1 || redirect_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_noevent_%0d: flush=%b ready=%b rv=%b required 0 1 0", n, flush, commit_ready, redirect_valid);
        end
      end else begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        redirect_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (redirect_valid !== 1'b0 || commit_ready !== 1'b1 || exc_count !== exp_count) begin
          errors++;
          $display("FAIL rand_event_%0d: rv=%b ready=%b cnt=%h required 0 1 %h", n, redirect_valid, commit_ready, exc_count, exp_count);
        end
      end
    end
  endtask

  task automatic test_reset_mid_redir();
    redirect_ready = 1'b0;
    exp_q.push_back(mk_exp(1'b1, 5'd12, 1'b0, 32'h8000_0700, 1'b0, 32'd0, 1'b0, VEC));
    drive_commit(32'h8000_0700, 1'b0, 7'h10, 32'd0, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (redirect_valid !== 1'b0 || commit_ready !== 1'b0 || exc_count !== 16'd0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL rst_redir: rv=%b ready=%b cnt=%h flush=%b required 0 0 0 0", redirect_valid, commit_ready, exc_count, flush);
    end
    rst = 1'b0;
    exp_count = 16'd0;
    @(posedge clk); #1;
    checks++;
    if (commit_ready !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_redir_release: ready=%b rv=%b required 1 0", commit_ready, redirect_valid);
    end
    redirect_ready = 1'b1;
  endtask

  // Starts the counter near the top and sends sys events back to back.
  task automatic test_back_to_back();
    force dut.exc_count = 16'hFFFA;
    #1;
    release dut.exc_count;
    exp_count = 16'hFFFA;
    redirect_ready = 1'b1;
    commit_valid = 1'b1; commit_exc = 7'h08; commit_pc = 32'h8000_0800; commit_bd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(mk_exp(1'b1, 5'd8, 1'b0, 32'h8000_0800, 1'b0, 32'd0, 1'b0, VEC));
      wait_ready();
      @(posedge clk); #1;
      if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
      checks++;
      if (exc_count !== exp_count) begin
        errors++;
        $display("FAIL b2b_count_%0d: cnt=%h required %h", i, exc_count, exp_count);
      end
    end
    commit_valid = 1'b0; commit_exc = '0;
    @(posedge clk); #1;
    checks++;
    if (exc_count !== 16'hFFFF || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_saturate: cnt=%h rv=%b required ffff 0", exc_count, redirect_valid);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_ov_hold();
    test_cause_table();
    test_eret();
    test_ignore_in_redir();
    test_random();
    test_reset_mid_redir();
    test_back_to_back();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
